// File: rtl/mips_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline.
// Holds the IF/ID register layout that fetch produces and decode consumes.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            oob;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    INSTR_NOP,
    pc_plus4: '0,
    valid:    1'b0,
    oob:      1'b0
  };

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter for the IF stage: reset / redirect / stall / increment
// priority mux plus word-alignment of every loaded address.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + PC_INC;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= align_pc(RESET_PC);
    end else if (i_redirect) begin
      r_pc <= align_pc(i_target_pc);
    end else if (!i_stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: drives the instruction memory address and fills the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] target_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt,
`endif
  output logic            if_id_oob
);

  localparam logic [XLEN-1:0] IMEM_WORDS_W = XLEN'(IMEM_WORDS);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_oob;
  logic            w_fetch;
  if_id_t          r_if_id;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .i_stall     (stall),
    .i_redirect  (redirect),
    .i_target_pc (target_pc),
    .o_pc        (w_pc),
    .o_pc_plus4  (w_pc_plus4)
  );

  assign imem_addr = w_pc;
  assign w_oob     = (w_pc >> 2) >= IMEM_WORDS_W;
  assign w_fetch   = !redirect && !stall;

  // A redirect squashes the wrong-path word fetched this cycle, even under stall.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (w_fetch) begin
      r_if_id <= '{instr: imem_data, pc_plus4: w_pc_plus4, valid: 1'b1, oob: w_oob};
    end
  end

  assign if_id_instr    = r_if_id.instr;
  assign if_id_pc_plus4 = r_if_id.pc_plus4;
  assign if_id_valid    = r_if_id.valid;
  assign if_id_oob      = r_if_id.oob;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_fetch_cnt;
  logic [XLEN-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch)              r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (stall && !redirect)   r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small instruction memory model.
// Expected values are hand-derived from the fetch rules (reset, stall, redirect, wrap).
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] target_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        if_id_oob;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [64];

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .target_pc      (target_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .if_id_oob      (if_id_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 64 words near zero, a recognisable pattern everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'd256) return mem[addr[7:2]];
    return {16'hC0DE, addr[15:0]};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid, input logic oob);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc_plus4, pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check({tag, ".oob"},   {31'd0, if_id_oob}, {31'd0, oob});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 2);
    mem[0] = 32'h8C10_0004;
    mem[1] = 32'h2011_0004;

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; target_pc = 32'h0;
    step();
    check_ifid("rst1", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_ifid("rst2", 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst_pc", imem_addr, 32'h0);
    reset = 1'b0;

    step();
    check("seq_pc1", imem_addr, 32'h4);
    check_ifid("seq1", 32'h8C10_0004, 32'h4, 1'b1, 1'b0);
    step();
    check("seq_pc2", imem_addr, 32'h8);
    check_ifid("seq2", 32'h2011_0004, 32'h8, 1'b1, 1'b0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", imem_addr, 32'h8);
      check_ifid("stall", 32'h2011_0004, 32'h8, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    check("unstall_pc", imem_addr, 32'hC);
    check_ifid("unstall", 32'hA000_0008, 32'hC, 1'b1, 1'b0);
    step();
    check("pc16", imem_addr, 32'h10);

    redirect = 1'b1; target_pc = 32'h0000_0043;
    step();
    check("redir_pc", imem_addr, 32'h40);
    check_ifid("redir_flush", 32'h0, 32'h0, 1'b0, 1'b0);
    redirect = 1'b0;
    step();
    check("redir_next_pc", imem_addr, 32'h44);
    check_ifid("redir_cap", 32'hA000_0040, 32'h44, 1'b1, 1'b0);

    redirect = 1'b1; stall = 1'b1; target_pc = 32'h20;
    step();
    check("rs_pc", imem_addr, 32'h20);
    check_ifid("rs_flush", 32'h0, 32'h0, 1'b0, 1'b0);
    redirect = 1'b0; stall = 1'b0;
    step();
    check("rs_next_pc", imem_addr, 32'h24);
    check_ifid("rs_cap", 32'hA000_0020, 32'h24, 1'b1, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd6);
    check("perf_stall", perf_stall_cnt, 32'd3);
`endif

    reset = 1'b1;
    step();
    check("mid_rst_pc", imem_addr, 32'h0);
    check_ifid("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
    reset = 1'b0;

    redirect = 1'b1; target_pc = 32'h80;
    step();
    check("b2b_pc1", imem_addr, 32'h80);
    target_pc = 32'h92;
    step();
    check("b2b_pc2", imem_addr, 32'h90);
    check_ifid("b2b", 32'h0, 32'h0, 1'b0, 1'b0);

    target_pc = 32'hFFC;
    step();
    redirect = 1'b0;
    step();
    check("last_word_pc", imem_addr, 32'h1000);
    check_ifid("last_word", 32'hC0DE_0FFC, 32'h1000, 1'b1, 1'b0);
    step();
    check_ifid("oob", 32'hC0DE_1000, 32'h1004, 1'b1, 1'b1);
    check("oob_pc", imem_addr, 32'h1004);

    redirect = 1'b1; target_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    check("top_pc", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", imem_addr, 32'h0);
    check_ifid("wrap", 32'hC0DE_FFFC, 32'h0, 1'b1, 1'b1);
    step();
    check("wrap_next_pc", imem_addr, 32'h4);
    check_ifid("wrap_next", 32'h8C10_0004, 32'h4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the instruction memory read address.
- Captures the returned 32-bit instruction plus PC+4 into the IF/ID pipeline register.
- Honours stall from the hazard unit and branch/jump redirect plus flush from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, number of 32-bit words in instruction memory; used for the out-of-range flag.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- redirect  in  1  ID stage: branch taken or jump; load target_pc.
- target_pc  in  32  redirect destination.
- imem_addr  out  32  byte address to the instruction memory read_address; equals pc.
- imem_data  in  32  instruction word returned combinationally by the instruction memory.
- if_id_instr  out  32  registered instruction.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction; 0 = bubble.
- if_id_oob  out  1  registered flag: the fetch address was beyond IMEM_WORDS.

Behaviour:
- Reset (sync, active-high) has priority over everything at the clock edge:
  - pc <= RESET_PC.
  - if_id_instr <= 32'h0000_0000 (NOP); if_id_pc_plus4 <= 0; if_id_valid <= 0; if_id_oob <= 0.
- Applies identically mid-operation; no pending redirect survives reset.
- imem_addr = pc, combinational; the memory returns imem_data in the same cycle.
- pc_plus4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- target_pc[1:0] is forced to 2'b00 when loaded. pc[1:0] is always 0.
- PC update at each edge (not in reset), by priority:
  1. redirect=1: pc <= {target_pc[31:2],2'b00}, regardless of stall.
  2. stall=1: pc holds.
  3. else: pc <= pc_plus4.
- IF/ID update at each edge (not in reset), by priority:
  1. redirect=1 (flush): instr <= NOP, pc_plus4 <= 0, valid <= 0, oob <= 0. This squashes the wrong-path instruction fetched this cycle.
  2. stall=1: all IF/ID fields hold.
  3. else: instr <= imem_data, pc_plus4 <= pc_plus4, valid <= 1, oob <= ((pc>>2) >= IMEM_WORDS).
- Redirect and stall in the same cycle: redirect wins for both PC and IF/ID.
- Latency: an instruction at address A appears on if_id_* one edge after pc==A with stall=0 and redirect=0.
- Back-to-back redirects: each one loads its own target; each cycle with redirect=1 yields a bubble.
- Out-of-range fetch:
  - imem_data is passed through unchanged.
  - if_id_oob=1 is the only effect.
  - The PC keeps advancing; there is no trap.

Optional Feature:
- FETCH_PERF_CNT_EN
- Defined:
  - Adds outputs perf_fetch_cnt [31:0] and perf_stall_cnt [31:0].
  - perf_fetch_cnt increments on every edge where IF/ID loads valid<=1.
  - perf_stall_cnt increments on every edge with stall=1 and redirect=0.
  - Both counters clear on reset and wrap modulo 2^32.
- Undefined: the ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package mips_pkg:
  - XLEN=32.
  - INSTR_NOP=32'h0000_0000.
  - PC_INC=32'd4.
  - A struct type if_id_t {instr, pc_plus4, valid, oob} shared with decode.
- One natural sub-module: pc_reg. It holds the PC register, the priority mux (reset/redirect/stall/increment) and the alignment masking.
- The IF/ID register stays in fetch_stage.

Test Plan:
- Reset sequence: reset=1 for 2 cycles, then released; memory holds word0=32'h8C10_0004 and word1=32'h2011_0004.
  - Required: imem_addr=0, 4, 8 on successive cycles.
  - Required: if_id_instr=8C100004 with pc_plus4=4, then 20110004 with pc_plus4=8.
  - Required: if_id_valid=0 during reset.
- Stall: assert stall for 3 cycles while pc=8.
  - Required: pc stays 8.
  - Required: if_id holds instr and pc_plus4=8 throughout.
  - Required: on release, the next edge loads the word at address 8 and pc becomes 12.
- Redirect: redirect=1 with target_pc=32'h0000_0043 while pc=16.
  - Required: next pc=0x40.
  - Required: if_id_valid=0 and instr=0 for that cycle.
  - Required: the following edge captures the word at 0x40 with pc_plus4=0x44.
- Redirect and stall together: both asserted with target_pc=0x20.
  - Required: pc=0x20 and if_id flushed (redirect priority).
- Out of range and wrap:
  - pc=0x1000 (word 1024) -> captured with if_id_oob=1.
  - pc=32'hFFFF_FFFC -> next pc=0.
- Mid-run reset: reset=1 while pc=0x24 with valid=1 -> next edge gives pc=RESET_PC, valid=0; with FETCH_PERF_CNT_EN defined, both counters read 0.
